// File: rtl/pipe_controller_pkg.sv
// Shared CPU control types and encodings (package lib_cpu) for the
// pipeline controller and its decoder.
package lib_cpu;

    typedef logic [5:0] OPECODE;
    typedef logic [5:0] FUNCT;
    typedef logic [1:0] FWD_SEL;

    localparam OPECODE OP_RTYPE = 6'b000000;
    localparam OPECODE OP_LW    = 6'b100011;
    localparam OPECODE OP_SW    = 6'b101011;
    localparam OPECODE OP_BEQ   = 6'b000100;
    localparam OPECODE OP_ADDI  = 6'b001000;
    localparam OPECODE OP_J     = 6'b000010;

    localparam FUNCT FN_ADD = 6'b100000;
    localparam FUNCT FN_SUB = 6'b100010;
    localparam FUNCT FN_AND = 6'b100100;
    localparam FUNCT FN_OR  = 6'b100101;
    localparam FUNCT FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam FWD_SEL FWD_REG = 2'b00;
    localparam FWD_SEL FWD_W   = 2'b01;
    localparam FWD_SEL FWD_M   = 2'b10;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_write;
        logic branch;
        logic alu_src;
        logic reg_dst;
        logic jump;
    } ctrl_t;

    // Unknown funct codes fall back to add so stray R-types stay harmless.
    function automatic logic [2:0] alu_decode(alu_op_t alu_op, FUNCT funct);
        logic [2:0] r;
        r = ALU_ADD;
        case (alu_op)
            ALU_OP_SUB: r = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct)
                    FN_ADD:  r = ALU_ADD;
                    FN_SUB:  r = ALU_SUB;
                    FN_AND:  r = ALU_AND;
                    FN_OR:   r = ALU_OR;
                    FN_SLT:  r = ALU_SLT;
                    default: r = ALU_ADD;
                endcase
            end
            default: r = ALU_ADD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipe_controller_if.sv
// Decode-stage inputs and per-stage control outputs of the pipeline controller.
// master = datapath side, slave = controller side.
interface pipe_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_CTRL_W = 3
);
    lib_cpu::OPECODE        op_d;
    lib_cpu::FUNCT          funct_d;
    logic [REG_ADDR_W-1:0]  rs_d;
    logic [REG_ADDR_W-1:0]  rt_d;
    logic [REG_ADDR_W-1:0]  rd_d;
    logic                   zero_e;

    logic                   stall_f;
    logic                   stall_d;
    logic                   flush_d;
    logic                   jmp_d;
    logic                   pc_src_e;
    logic                   alu_src_e;
    logic                   reg_dst_e;
    logic [ALU_CTRL_W-1:0]  alu_ctrl_e;
    lib_cpu::FWD_SEL        fwd_a_e;
    lib_cpu::FWD_SEL        fwd_b_e;
    logic                   write_enab_m;
    logic                   reg_write_w;
    logic                   mem_to_reg_w;
    logic [REG_ADDR_W-1:0]  write_reg_w;

    modport master (
        output op_d, funct_d, rs_d, rt_d, rd_d, zero_e,
        input  stall_f, stall_d, flush_d, jmp_d, pc_src_e, alu_src_e, reg_dst_e,
               alu_ctrl_e, fwd_a_e, fwd_b_e, write_enab_m, reg_write_w,
               mem_to_reg_w, write_reg_w
    );

    modport slave (
        input  op_d, funct_d, rs_d, rt_d, rd_d, zero_e,
        output stall_f, stall_d, flush_d, jmp_d, pc_src_e, alu_src_e, reg_dst_e,
               alu_ctrl_e, fwd_a_e, fwd_b_e, write_enab_m, reg_write_w,
               mem_to_reg_w, write_reg_w
    );
endinterface

// File: rtl/pipe_controller_decoder.sv
// Combinational D-stage decoder (pipe_decoder): opcode/funct to control bundle.
// Unrecognised opcodes give an all-zero bundle, ALU control included.
module pipe_decoder
    import lib_cpu::*;
#(
    parameter int ALU_CTRL_W = 3
) (
    input  OPECODE                op,
    input  FUNCT                  funct,
    output ctrl_t                 ctrl,
    output logic [ALU_CTRL_W-1:0] alu_ctrl
);

    alu_op_t alu_op;
    logic    known;

    always_comb begin
        ctrl   = '0;
        alu_op = ALU_OP_ADD;
        known  = 1'b1;
        case (op)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                alu_op         = ALU_OP_FUNCT;
            end
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                alu_op      = ALU_OP_SUB;
            end
            OP_ADDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OP_J:    ctrl.jump = 1'b1;
            default: known = 1'b0;
        endcase
        alu_ctrl = known ? ALU_CTRL_W'(alu_decode(alu_op, funct)) : '0;
    end

endmodule

// File: rtl/pipe_controller.sv
// Pipeline controller: D->E->M->W control registers, hazard stall/flush and
// operand forwarding. Define PIPE_CTRL_FORWARD_EN for forwarding; without it,
// any E/M dependency stalls and forwarding stays at the register file.
module pipe_controller
    import lib_cpu::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_CTRL_W = 3
) (
    input  logic      clk,
    input  logic      reset,
    pipe_ctrl_if.slave bus
);

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  mem_write;
        logic                  branch;
        logic                  alu_src;
        logic                  reg_dst;
        logic [ALU_CTRL_W-1:0] alu_ctrl;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] rd;
    } e_reg_t;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic                  mem_write;
        logic [REG_ADDR_W-1:0] write_reg;
    } m_reg_t;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic [REG_ADDR_W-1:0] write_reg;
    } w_reg_t;

    ctrl_t                 ctrl_d;
    logic [ALU_CTRL_W-1:0] alu_ctrl_d;
    e_reg_t                e_q, e_d;
    m_reg_t                m_q;
    w_reg_t                w_q;
    logic [REG_ADDR_W-1:0] write_reg_e;
    logic                  pc_src, hazard, stall, bubble_e;

    function automatic logic dep(logic [REG_ADDR_W-1:0] src, logic we,
                                 logic [REG_ADDR_W-1:0] dst);
        return we && (src != '0) && (src == dst);
    endfunction

    pipe_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_decoder (
        .op       (bus.op_d),
        .funct    (bus.funct_d),
        .ctrl     (ctrl_d),
        .alu_ctrl (alu_ctrl_d)
    );

    assign write_reg_e = e_q.reg_dst ? e_q.rd : e_q.rt;
    assign pc_src      = e_q.branch & bus.zero_e;
    // A taken branch kills both the stalled instruction and any jump in D.
    assign stall       = hazard & ~pc_src;
    assign bubble_e    = stall | pc_src;

`ifdef PIPE_CTRL_FORWARD_EN
    logic [REG_ADDR_W-1:0] rs_e;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         rs_e <= '0;
        else if (bubble_e) rs_e <= '0;
        else               rs_e <= bus.rs_d;
    end

    assign hazard = e_q.mem_to_reg & (dep(bus.rs_d, e_q.reg_write, e_q.rt) |
                                      dep(bus.rt_d, e_q.reg_write, e_q.rt));
    assign bus.fwd_a_e = dep(rs_e, m_q.reg_write, m_q.write_reg) ? FWD_M :
                         dep(rs_e, w_q.reg_write, w_q.write_reg) ? FWD_W : FWD_REG;
    assign bus.fwd_b_e = dep(e_q.rt, m_q.reg_write, m_q.write_reg) ? FWD_M :
                         dep(e_q.rt, w_q.reg_write, w_q.write_reg) ? FWD_W : FWD_REG;
`else
    assign hazard = dep(bus.rs_d, e_q.reg_write, write_reg_e) |
                    dep(bus.rt_d, e_q.reg_write, write_reg_e) |
                    dep(bus.rs_d, m_q.reg_write, m_q.write_reg) |
                    dep(bus.rt_d, m_q.reg_write, m_q.write_reg);
    assign bus.fwd_a_e = FWD_REG;
    assign bus.fwd_b_e = FWD_REG;
`endif

    always_comb begin
        e_d = '0;
        if (!bubble_e) begin
            e_d.reg_write  = ctrl_d.reg_write;
            e_d.mem_to_reg = ctrl_d.mem_to_reg;
            e_d.mem_write  = ctrl_d.mem_write;
            e_d.branch     = ctrl_d.branch;
            e_d.alu_src    = ctrl_d.alu_src;
            e_d.reg_dst    = ctrl_d.reg_dst;
            e_d.alu_ctrl   = alu_ctrl_d;
            e_d.rt         = bus.rt_d;
            e_d.rd         = bus.rd_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q.reg_write  <= e_q.reg_write;
            m_q.mem_to_reg <= e_q.mem_to_reg;
            m_q.mem_write  <= e_q.mem_write;
            m_q.write_reg  <= write_reg_e;
            w_q.reg_write  <= m_q.reg_write;
            w_q.mem_to_reg <= m_q.mem_to_reg;
            w_q.write_reg  <= m_q.write_reg;
        end
    end

    // Decode is combinational, so the jump output is masked during reset.
    assign bus.jmp_d        = ctrl_d.jump & ~pc_src & ~reset;
    assign bus.flush_d      = pc_src | bus.jmp_d;
    assign bus.stall_f      = stall;
    assign bus.stall_d      = stall;
    assign bus.pc_src_e     = pc_src;
    assign bus.alu_src_e    = e_q.alu_src;
    assign bus.reg_dst_e    = e_q.reg_dst;
    assign bus.alu_ctrl_e   = e_q.alu_ctrl;
    assign bus.write_enab_m = m_q.mem_write;
    assign bus.reg_write_w  = w_q.reg_write;
    assign bus.mem_to_reg_w = w_q.mem_to_reg;
    assign bus.write_reg_w  = w_q.write_reg;

endmodule

// File: tb/tb_pipe_controller.sv
// Scoreboard bench for pipe_controller: each driven cycle queues its expected
// outputs, and a negedge monitor pops and compares them.
module tb_pipe_controller;
    import lib_cpu::*;

    localparam int O_R = 0, O_LW = 35, O_SW = 43, O_BEQ = 4, O_ADDI = 8, O_J = 2, O_NOP = 63;
    localparam int F_ADD = 32, F_SUB = 34, F_AND = 36, F_OR = 37, F_SLT = 42, F_BAD = 63;
    localparam int A_ADD = 2, A_SUB = 6, A_AND = 0, A_OR = 1, A_SLT = 7;

    typedef struct packed {
        logic       stall_f, stall_d, flush, jmp, pc_src, alu_src, reg_dst;
        logic [2:0] alu;
        logic [1:0] fa, fb;
        logic       we, rw, mtr;
        logic [4:0] wr;
    } obs_t;

    localparam obs_t Z = '0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.REG_ADDR_W(5), .ALU_CTRL_W(3)) bus ();
    pipe_controller #(.REG_ADDR_W(5), .ALU_CTRL_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    obs_t exp_q[$];
    int   row_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   row = 0;

    function automatic obs_t ex(input int st, fl, jm, pc, as, rdst, alu,
                                fa, fb, we, rw, mtr, wr);
        obs_t e;
        e.stall_f = 1'(st);  e.stall_d = 1'(st);
        e.flush   = 1'(fl);  e.jmp     = 1'(jm);  e.pc_src = 1'(pc);
        e.alu_src = 1'(as);  e.reg_dst = 1'(rdst); e.alu   = 3'(alu);
        e.fa      = 2'(fa);  e.fb      = 2'(fb);
        e.we      = 1'(we);  e.rw      = 1'(rw);  e.mtr    = 1'(mtr);
        e.wr      = 5'(wr);
        return e;
    endfunction

    task automatic step(input int rst, op, fn, rs, rt, rd, z, input obs_t e);
        @(posedge clk);
        #1;
        reset       = 1'(rst);
        bus.op_d    = 6'(op);
        bus.funct_d = 6'(fn);
        bus.rs_d    = 5'(rs);
        bus.rt_d    = 5'(rt);
        bus.rd_d    = 5'(rd);
        bus.zero_e  = 1'(z);
        exp_q.push_back(e);
        row_q.push_back(row);
        row++;
    endtask

    task automatic nop(input obs_t e);
        step(0, O_NOP, 0, 0, 0, 0, 0, e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t a;
            obs_t e;
            int   r;
            e = exp_q.pop_front();
            r = row_q.pop_front();
            a.stall_f = bus.stall_f;     a.stall_d = bus.stall_d;
            a.flush   = bus.flush_d;     a.jmp     = bus.jmp_d;
            a.pc_src  = bus.pc_src_e;    a.alu_src = bus.alu_src_e;
            a.reg_dst = bus.reg_dst_e;   a.alu     = bus.alu_ctrl_e;
            a.fa      = bus.fwd_a_e;     a.fb      = bus.fwd_b_e;
            a.we      = bus.write_enab_m; a.rw     = bus.reg_write_w;
            a.mtr     = bus.mem_to_reg_w; a.wr     = bus.write_reg_w;
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL row%0d outputs (stf std fl jmp pc as rdst alu fa fb we rw mtr wr): got %b required %b",
                         r, a, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", exp_q.size());
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.op_d = 6'(O_NOP); bus.funct_d = '0; bus.rs_d = '0; bus.rt_d = '0; bus.rd_d = '0; bus.zero_e = 1'b0;

        // reset with a jump in D: every output low
        step(1, O_J, 0, 0, 0, 0, 0, Z);

        // add r3,r1,r2 ; sub r4,r3,r5
        step(0, O_R, F_ADD, 1, 2, 3, 0, Z);
`ifdef PIPE_CTRL_FORWARD_EN
        step(0, O_R, F_SUB, 3, 5, 4, 0, ex(0,0,0,0, 0,1,A_ADD, 0,0, 0,0,0,0));
        nop(ex(0,0,0,0, 0,1,A_SUB, 2,0, 0,0,0,0));
        nop(ex(0,0,0,0, 0,0,0,     0,0, 0,1,0,3));
        nop(ex(0,0,0,0, 0,0,0,     0,0, 0,1,0,4));
        nop(Z);
`else
        step(0, O_R, F_SUB, 3, 5, 4, 0, ex(1,0,0,0, 0,1,A_ADD, 0,0, 0,0,0,0));
        step(0, O_R, F_SUB, 3, 5, 4, 0, ex(1,0,0,0, 0,0,0,     0,0, 0,0,0,0));
        step(0, O_R, F_SUB, 3, 5, 4, 0, ex(0,0,0,0, 0,0,0,     0,0, 0,1,0,3));
        nop(ex(0,0,0,0, 0,1,A_SUB, 0,0, 0,0,0,0));
        nop(Z);
        nop(ex(0,0,0,0, 0,0,0,     0,0, 0,1,0,4));
        nop(Z);
`endif

        // lw r2,0(r1) ; add r4,r2,r2
        step(0, O_LW, 0, 1, 2, 0, 0, Z);
        step(0, O_R, F_ADD, 2, 2, 4, 0, ex(1,0,0,0, 1,0,A_ADD, 0,0, 0,0,0,0));
`ifdef PIPE_CTRL_FORWARD_EN
        step(0, O_R, F_ADD, 2, 2, 4, 0, Z);
        nop(ex(0,0,0,0, 0,1,A_ADD, 1,1, 0,1,1,2));
        nop(Z);
        nop(ex(0,0,0,0, 0,0,0,     0,0, 0,1,0,4));
        nop(Z);
`else
        step(0, O_R, F_ADD, 2, 2, 4, 0, ex(1,0,0,0, 0,0,0, 0,0, 0,0,0,0));
        step(0, O_R, F_ADD, 2, 2, 4, 0, ex(0,0,0,0, 0,0,0, 0,0, 0,1,1,2));
        nop(ex(0,0,0,0, 0,1,A_ADD, 0,0, 0,0,0,0));
        nop(Z);
        nop(ex(0,0,0,0, 0,0,0,     0,0, 0,1,0,4));
        nop(Z);
`endif

        // beq taken in E with j in D, then a plain jump, then beq not taken
        step(0, O_BEQ, 0, 1, 2, 0, 0, Z);
        step(0, O_J,   0, 0, 0, 0, 1, ex(0,1,0,1, 0,0,A_SUB, 0,0, 0,0,0,0));
        step(0, O_NOP, 0, 0, 0, 0, 1, Z);
        step(0, O_J,   0, 0, 0, 0, 0, ex(0,1,1,0, 0,0,0,     0,0, 0,0,0,2));
        nop(ex(0,0,0,0, 0,0,A_ADD, 0,0, 0,0,0,0));
        step(0, O_BEQ, 0, 6, 7, 0, 0, Z);
        nop(ex(0,0,0,0, 0,0,A_SUB, 0,0, 0,0,0,0));
        nop(Z);
        nop(ex(0,0,0,0, 0,0,0,     0,0, 0,0,0,7));
        nop(Z);

        // taken branch overrides the dependency stall of the instruction in D
        step(0, O_R,   F_ADD, 1, 2, 3, 0, Z);
        step(0, O_BEQ, 0,     6, 7, 0, 0, ex(0,0,0,0, 0,1,A_ADD, 0,0, 0,0,0,0));
        step(0, O_R,   F_SUB, 3, 5, 4, 1, ex(0,1,0,1, 0,0,A_SUB, 0,0, 0,0,0,0));
        nop(ex(0,0,0,0, 0,0,0, 0,0, 0,1,0,3));
        nop(ex(0,0,0,0, 0,0,0, 0,0, 0,0,0,7));
        nop(Z);

        // add r0,r1,r2 ; or r5,r0,r0: register 0 never forwards or stalls
        step(0, O_R, F_ADD, 1, 2, 0, 0, Z);
        step(0, O_R, F_OR,  0, 0, 5, 0, ex(0,0,0,0, 0,1,A_ADD, 0,0, 0,0,0,0));
        nop(ex(0,0,0,0, 0,1,A_OR, 0,0, 0,0,0,0));
        nop(ex(0,0,0,0, 0,0,0,    0,0, 0,1,0,0));
        nop(ex(0,0,0,0, 0,0,0,    0,0, 0,1,0,5));
        nop(Z);

        // decode coverage and stage timing: sw, addi, and, slt, unknown funct
        step(0, O_SW,   0,     1,  2,  0,  0, Z);
        step(0, O_ADDI, 0,     1,  6,  0,  0, ex(0,0,0,0, 1,0,A_ADD, 0,0, 0,0,0,0));
        step(0, O_R,    F_AND, 8,  9,  7,  0, ex(0,0,0,0, 1,0,A_ADD, 0,0, 1,0,0,0));
        step(0, O_R,    F_SLT, 11, 12, 10, 0, ex(0,0,0,0, 0,1,A_AND, 0,0, 0,0,0,2));
        step(0, O_R,    F_BAD, 14, 15, 13, 0, ex(0,0,0,0, 0,1,A_SLT, 0,0, 0,1,0,6));
        nop(ex(0,0,0,0, 0,1,A_ADD, 0,0, 0,1,0,7));
        nop(ex(0,0,0,0, 0,0,0,     0,0, 0,1,0,10));
        nop(ex(0,0,0,0, 0,0,0,     0,0, 0,1,0,13));
        nop(Z);

        // reset asserted during a load-use stall clears everything at once
        step(0, O_LW, 0,     1, 2, 0, 0, Z);
        step(0, O_R,  F_ADD, 2, 2, 4, 0, ex(1,0,0,0, 1,0,A_ADD, 0,0, 0,0,0,0));
        step(1, O_R,  F_ADD, 2, 2, 4, 0, Z);
        step(0, O_R,  F_ADD, 2, 2, 4, 0, Z);
        nop(ex(0,0,0,0, 0,1,A_ADD, 0,0, 0,0,0,0));
        nop(Z);
        nop(ex(0,0,0,0, 0,0,0,     0,0, 0,1,0,4));
        nop(Z);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_controller.md
PIPE_CONTROLLER -- requirements
Module: pipe_controller

Interface
REQ-001 Parameter REG_ADDR_W, default 5, register-address width.
REQ-002 Parameter ALU_CTRL_W, default 3, ALU control width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 op_d  input  OPECODE  opcode of the instruction in D.
REQ-006 funct_d  input  FUNCT  funct field in D.
REQ-007 rs_d, rt_d, rd_d  input  REG_ADDR_W each  register fields in D.
REQ-008 zero_e  input  1  ALU zero flag in E.
REQ-009 stall_f, stall_d  output  1 each  hold PC and the IF/ID register.
REQ-010 flush_d  output  1  clear the IF/ID register.
REQ-011 jmp_d  output  1  jump taken in D.
REQ-012 pc_src_e  output  1  branch taken in E.
REQ-013 alu_src_e, reg_dst_e  output  1 each; alu_ctrl_e  output  ALU_CTRL_W.
REQ-014 fwd_a_e, fwd_b_e  output  FWD_SEL (2)  operand source: 00 regfile, 01 W result, 10 M result.
REQ-015 write_enab_m  output  1  data-memory write.
REQ-016 reg_write_w, mem_to_reg_w  output  1 each; write_reg_w  output  REG_ADDR_W.

Function
REQ-017 D decode is combinational: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010; any other opcode decodes to all-zero controls (NOP).
REQ-018 ALU control follows the existing 2-bit alu_op scheme: 00 add, 01 sub, 10 funct-decoded (add 010, sub 110, and 000, or 001, slt 111); undefined funct yields 010.
REQ-019 The control bundle is registered D->E->M->W; an instruction in D in cycle n drives its E controls in n+1, write_enab_m in n+2 and reg_write_w/mem_to_reg_w in n+3.
REQ-020 write_reg is formed in E as reg_dst_e ? rd_e : rt_e, then piped to M and W.
REQ-021 Load-use: if mem_to_reg_e & reg_write_e & rt_e != 0 & (rt_e == rs_d | rt_e == rt_d), then stall_f = stall_d = 1 and the E register loads a bubble (all controls zero).
REQ-022 Forwarding (per operand, rs_e for A, rt_e for B):
- 10 if reg_write_m & write_reg_m != 0 & write_reg_m matches;
- else 01 if reg_write_w & write_reg_w != 0 & write_reg_w matches;
- else 00.
REQ-023 Register 0 never causes a forward or a stall.
REQ-024 pc_src_e = branch_e & zero_e; when it is 1, flush_d = 1 and the E register loads a bubble on the next edge.
REQ-025 jmp_d = 1 for a decoded j in D unless pc_src_e = 1; a jump asserts flush_d for that cycle.
REQ-026 A taken branch overrides any simultaneous load-use stall or jump: stall_f = stall_d = jmp_d = 0.
REQ-027 While stalled, the D-to-E register fields hold, and M and W advance normally.

Reset
REQ-028 With reset = 1, all pipeline control registers clear to zero immediately without waiting for clk, giving:
- every output 0;
- fwd_a_e = fwd_b_e = 00;
- write_reg_w = 0.
REQ-029 Reset asserted mid-stall or mid-flush discards all in-flight control; the first cycle after release decodes op_d normally.

Configuration
REQ-030 Macro PIPE_CTRL_FORWARD_EN defined: forwarding per REQ-022 and stall only per REQ-021.
REQ-031 Macro absent:
- fwd_a_e = fwd_b_e = 00 permanently.
- Stall (REQ-021 semantics) whenever rs_d or rt_d (nonzero) equals write_reg_e with reg_write_e, or write_reg_m with reg_write_m.
- W-stage hazards rely on the register file's write-first behaviour.

Structure
REQ-032 OPECODE, FUNCT, FWD_SEL, opcode constants, alu_op encodings and the ALU control constants live in lib_cpu.
REQ-033 The combinational decoder is the sub-module pipe_decoder; pipeline registers and hazard logic stay in pipe_controller.

Verification
REQ-034 add r3,r1,r2 followed by sub r4,r3,r5 -> fwd_a_e = 10 in the cycle the sub is in E.
REQ-035 lw r2,0(r1) followed by add r4,r2,r2:
- stall_f = stall_d = 1 for exactly one cycle;
- a bubble in E;
- then fwd_a_e = fwd_b_e = 01.
REQ-036 beq with zero_e = 1 -> pc_src_e = 1, flush_d = 1, and next-cycle E controls all 0.
REQ-037 j in D while beq is taken in E -> jmp_d = 0 and pc_src_e = 1.
REQ-038 add r0,r1,r2 followed by or r5,r0,r0 -> fwd 00 and no stall.
REQ-039 reset pulsed during a load-use stall -> all outputs 0 asynchronously, and normal decode on the following edge; repeat REQ-034 without PIPE_CTRL_FORWARD_EN -> two stall cycles and fwd 00.
